codifica_hamming_tx: RTL

Hamming(15,11) encoder and serial transmitter; the transmit-side counterpart of the corrige_hamming decoder.
- Accepts 11-bit data words over a valid/ready handshake and computes the 15-bit codeword with the same bit layout the decoder expects.
- Optionally flips one codeword bit for link and decoder testing.
- Sends each codeword as a UART-style serial frame, and also presents the codeword in parallel.

---
 rtl/codifica_hamming_tx_if.sv | 22 ++
 rtl/codifica_hamming_tx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/codifica_hamming_tx_if.sv
// Word-in / codeword-out bus of the Hamming(15,11) serial transmitter.
// The slave side is the encoder; the master side feeds words and watches the line.
interface codifica_hamming_tx_if;
   logic [10:0] entrada;
   logic        entrada_valid;
   logic        entrada_ready;
   logic [3:0]  injeta_pos;
   logic [14:0] codigo;
   logic        codigo_valid;
   logic        tx;
   logic        ocupado;

   modport slave (
      input  entrada, entrada_valid, injeta_pos,
      output entrada_ready, codigo, codigo_valid, tx, ocupado
   );

   modport master (
      output entrada, entrada_valid, injeta_pos,
      input  entrada_ready, codigo, codigo_valid, tx, ocupado
   );
endinterface

// File: rtl/codifica_hamming_tx.sv
// Hamming(15,11) encoder with optional single-bit error injection, a one-word
// holding buffer and a UART-style serializer (start, 15 bits LSB first, stop).
//
// state | meaning
// IDLE  | line high; loads the holding buffer into the shifter when it is full
// START | start bit (line low) for CLKS_PER_BIT cycles
// DATA  | codeword bits 0..14, each held for CLKS_PER_BIT cycles
// STOP  | stop bit (line high) for CLKS_PER_BIT cycles
module codifica_hamming_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input logic               clk,
   input logic               rst_n,
   codifica_hamming_tx_if.slave bus
);
   localparam int BW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q;
   logic [BW-1:0] baud_q;
   logic [3:0]    bit_q;
   logic [14:0]   shift_q;
   logic [14:0]   buf_q;
   logic          buf_full_q;
   logic          rdy_q;
   logic [14:0]   codigo_q;
   logic          codigo_valid_q;
   logic          tx_q;
   logic          ocupado_q;

   logic [14:0]   cw;
   logic [14:0]   flip;
   logic [14:0]   enc_d;
   logic          accept;
   logic          baud_end;

   always_comb begin
      cw        = '0;
      cw[2]     = bus.entrada[0];
      cw[6:4]   = bus.entrada[3:1];
      cw[14:8]  = bus.entrada[10:4];
      cw[0]     = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14];
      cw[1]     = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14];
      cw[3]     = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
      cw[7]     = ^cw[14:8];
      flip      = (bus.injeta_pos != 4'd0) ? (15'd1 << (bus.injeta_pos - 4'd1)) : 15'd0;
      enc_d     = cw ^ flip;
   end

   // rdy_q keeps ready low while reset is held and for the release cycle
   assign bus.entrada_ready = rdy_q & ~buf_full_q;
   assign accept            = bus.entrada_valid & bus.entrada_ready;
   assign baud_end          = (baud_q == BAUD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         baud_q         <= '0;
         bit_q          <= '0;
         shift_q        <= '0;
         buf_q          <= '0;
         buf_full_q     <= 1'b0;
         rdy_q          <= 1'b0;
         codigo_q       <= '0;
         codigo_valid_q <= 1'b0;
         tx_q           <= 1'b1;
         ocupado_q      <= 1'b0;
      end else begin
         rdy_q          <= 1'b1;
         codigo_valid_q <= 1'b0;
         if (accept) begin
            buf_q      <= enc_d;
            buf_full_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (buf_full_q) begin
                  shift_q        <= buf_q;
                  codigo_q       <= buf_q;
                  codigo_valid_q <= 1'b1;
                  buf_full_q     <= 1'b0;
                  tx_q           <= 1'b0;
                  ocupado_q      <= 1'b1;
                  baud_q         <= '0;
                  state_q        <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 4'd14) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_q   <= bit_q + 4'd1;
                     shift_q <= {1'b0, shift_q[14:1]};
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_q    <= '0;
                  ocupado_q <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.codigo       = codigo_q;
   assign bus.codigo_valid = codigo_valid_q;
   assign bus.tx           = tx_q;
   assign bus.ocupado      = ocupado_q;
endmodule
